blink_sequencer: RTL and testbench

- Programmable LED blink controller that sequences a single LED output through repeating bursts.
- Each burst is burst_len blinks, each blink on_ticks ON then off_ticks OFF, followed by a pause_ticks gap; the burst pattern repeats until stopped.
- Timing base is an internal tick prescaler derived from clk.
- Sits between board-level control (buttons/switches) and the LED pin; replaces free-running blink logic with a start/stop-controlled, configurable sequencer.

---
 rtl/blink_sequencer_pkg.sv | 12 +
 rtl/tick_prescaler.sv | 20 ++
 rtl/blink_sequencer.sv | 96 +++++++++
 tb/tb_blink_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/blink_sequencer_pkg.sv
// blink_sequencer_pkg: shared state encodings and default sizing for the blink sequencer
package blink_sequencer_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;
  localparam int DEF_CLK_DIV = 50000;
  localparam int DEF_TICK_W  = 16;
  localparam int DEF_CNT_W   = 4;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: one-cycle tick every CLK_DIV enabled clocks
// Ports: clk, rst (async high), clr (sync count clear), en (count enable), tick (pulse out).
module tick_prescaler #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  logic [W-1:0] r_cnt;
  assign tick = en && r_cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en) r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: start/stop-controlled LED burst sequencer
// Ports: clk, rst (async high); start/stop level requests; on_ticks/off_ticks/pause_ticks
// and burst_len config (latched at start); ledpin, busy, burst_done registered outputs.
module blink_sequencer
  import blink_sequencer_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int TICK_W  = DEF_TICK_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TICK_W-1:0] on_ticks,
  input  logic [TICK_W-1:0] off_ticks,
  input  logic [TICK_W-1:0] pause_ticks,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              ledpin,
  output logic              busy,
  output logic              burst_done
);
  state_t r_state, w_state_nxt;
  logic [TICK_W-1:0] r_on, r_off, r_pause, r_tcnt, w_tcnt_nxt, w_dur;
  logic [CNT_W-1:0] r_len, r_blinks, w_blinks_nxt;
  logic r_led, r_busy, r_done;
  logic w_tick, w_start, w_phase_end, w_last_blink, w_done_nxt, w_clr;
  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_pre (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (r_state != S_IDLE),
    .tick(w_tick)
  );
  assign w_start = r_state == S_IDLE && start && !stop && burst_len != '0;
  assign w_dur = r_state == S_ON ? r_on : r_state == S_OFF ? r_off : r_pause;
  // a zero duration behaves as one tick; PAUSE is never entered with zero
  assign w_phase_end = w_tick && r_tcnt == (w_dur == '0 ? '0 : w_dur - TICK_W'(1));
  assign w_last_blink = r_blinks + CNT_W'(1) == r_len;
  // prescaler restarts on every state change so each phase lasts whole ticks
  assign w_clr = w_state_nxt != r_state;
  always_comb begin
    w_state_nxt = r_state;
    w_blinks_nxt = r_blinks;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_state_nxt = S_ON;
        w_blinks_nxt = '0;
      end
      S_ON: if (w_phase_end) w_state_nxt = S_OFF;
      S_OFF: if (w_phase_end) begin
        w_blinks_nxt = w_last_blink ? '0 : r_blinks + CNT_W'(1);
        w_done_nxt = w_last_blink;
        w_state_nxt = w_last_blink && r_pause != '0 ? S_PAUSE : S_ON;
      end
      default: if (w_phase_end) w_state_nxt = S_ON;
    endcase
    // stop overrides any phase change, including a pending done pulse
    if (r_state != S_IDLE && stop) begin
      w_state_nxt = S_IDLE;
      w_blinks_nxt = '0;
      w_done_nxt = 1'b0;
    end
    w_tcnt_nxt = w_state_nxt != r_state ? '0 : w_tick ? r_tcnt + TICK_W'(1) : r_tcnt;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= S_IDLE;
      r_tcnt <= '0;
      r_blinks <= '0;
      r_on <= '0;
      r_off <= '0;
      r_pause <= '0;
      r_len <= '0;
      r_led <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_blinks <= w_blinks_nxt;
      r_led <= w_state_nxt == S_ON;
      r_busy <= w_state_nxt != S_IDLE;
      r_done <= w_done_nxt;
      if (w_start) begin
        r_on <= on_ticks;
        r_off <= off_ticks;
        r_pause <= pause_ticks;
        r_len <= burst_len;
      end
    end
  assign ledpin = r_led;
  assign busy = r_busy;
  assign burst_done = r_done;
endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: scoreboard bench checking per-cycle LED waveform against expected vectors
module tb_blink_sequencer;
  localparam int DIV = 2;
  typedef struct {
    int   cyc;
    logic led;
    logic busy;
    logic done;
  } exp_t;
  logic clk = 1'b0;
  logic rst, start, stop;
  logic [15:0] on_ticks, off_ticks, pause_ticks;
  logic [3:0] burst_len;
  logic ledpin, busy, burst_done;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  bit [1:0] mq[$];
  bit pend;
  blink_sequencer #(.CLK_DIV(DIV), .TICK_W(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .on_ticks   (on_ticks),
    .off_ticks  (off_ticks),
    .pause_ticks(pause_ticks),
    .burst_len  (burst_len),
    .ledpin     (ledpin),
    .busy       (busy),
    .burst_done (burst_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale expectation cyc %0d (now %0d)", sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({ledpin, busy, burst_done} !== {e.led, e.busy, e.done}) begin
        errors++;
        $display("FAIL wave cyc %0d led/busy/done got %b%b%b exp %b%b%b",
                 cyc, ledpin, busy, burst_done, e.led, e.busy, e.done);
      end
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic goto(int k);
    while (cyc < k) step();
  endtask
  function automatic void exp_idle(int c0, int n);
    for (int i = 0; i < n; i++) sb.push_back('{cyc: c0 + i, led: 1'b0, busy: 1'b0, done: 1'b0});
  endfunction
  function automatic void add(bit led, int k);
    for (int i = 0; i < k; i++) begin
      mq.push_back({led, pend});
      pend = 1'b0;
    end
  endfunction
  // waveform model: ON max(on,1)*DIV, OFF max(off,1)*DIV per blink, done on the cycle after the last OFF
  function automatic void expect_run(int c0, int on, int off, int len, int pause, int n);
    int eon = on == 0 ? 1 : on;
    int eoff = off == 0 ? 1 : off;
    mq.delete();
    pend = 1'b0;
    while (mq.size() < n) begin
      for (int b = 0; b < len; b++) begin
        add(1'b1, eon * DIV);
        add(1'b0, eoff * DIV);
      end
      pend = 1'b1;
      add(1'b0, pause * DIV);
    end
    for (int i = 0; i < n; i++) sb.push_back('{cyc: c0 + i, led: mq[i][1], busy: 1'b1, done: mq[i][0]});
  endfunction
  task automatic cfg(int on, int off, int pause, int len);
    on_ticks = 16'(on);
    off_ticks = 16'(off);
    pause_ticks = 16'(pause);
    burst_len = 4'(len);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg(0, 0, 0, 0);
    exp_idle(1, 3);
    goto(2);
    rst = 1'b0;
    goto(3);
    cfg(3, 2, 4, 0);
    start = 1'b1;
    exp_idle(4, 6);
    step();
    start = 1'b0;
    goto(9);
    cfg(3, 2, 4, 2);
    start = 1'b1;
    expect_run(10, 3, 2, 2, 4, 56);
    step();
    start = 1'b0;
    goto(65);
    stop = 1'b1;
    exp_idle(66, 3);
    step();
    stop = 1'b0;
    goto(68);
    cfg(0, 0, 0, 1);
    start = 1'b1;
    expect_run(69, 0, 0, 1, 0, 20);
    step();
    start = 1'b0;
    goto(88);
    stop = 1'b1;
    exp_idle(89, 3);
    step();
    stop = 1'b0;
    goto(91);
    cfg(3, 2, 4, 2);
    start = 1'b1;
    expect_run(92, 3, 2, 2, 4, 3);
    step();
    start = 1'b0;
    goto(94);
    stop = 1'b1;
    exp_idle(95, 2);
    step();
    stop = 1'b0;
    goto(96);
    start = 1'b1;
    expect_run(97, 3, 2, 2, 4, 12);
    step();
    start = 1'b0;
    goto(108);
    start = 1'b1;
    stop = 1'b1;
    exp_idle(109, 3);
    step();
    start = 1'b0;
    stop = 1'b0;
    goto(111);
    start = 1'b1;
    stop = 1'b1;
    exp_idle(112, 3);
    step();
    start = 1'b0;
    stop = 1'b0;
    goto(114);
    start = 1'b1;
    expect_run(115, 3, 2, 2, 4, 24);
    step();
    start = 1'b0;
    goto(118);
    cfg(1, 2, 4, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    goto(138);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ledpin, busy, burst_done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset led/busy/done got %b%b%b exp 000", ledpin, busy, burst_done);
    end
    exp_idle(139, 3);
    step();
    rst = 1'b0;
    goto(141);
    start = 1'b1;
    expect_run(142, 1, 2, 2, 4, 20);
    step();
    start = 1'b0;
    goto(161);
    stop = 1'b1;
    exp_idle(162, 3);
    step();
    stop = 1'b0;
    goto(166);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
